// File: rtl/cache_pkg.sv
// Shared cache geometry, refill FSM states and word-address split helpers
// for the direct-mapped cache (256 lines x 16 words).
package cache_pkg;

    localparam int TAG_W      = 20;
    localparam int INDEX_W    = 8;
    localparam int OFFSET_W   = 4;
    localparam int LINE_WORDS = 16;
    localparam int ADDR_W     = TAG_W + INDEX_W + OFFSET_W;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } refill_state_t;

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] addr);
        return TAG_W'(addr >> (INDEX_W + OFFSET_W));
    endfunction

    function automatic logic [INDEX_W-1:0] index_of(input logic [ADDR_W-1:0] addr);
        return INDEX_W'(addr >> OFFSET_W);
    endfunction

    function automatic logic [OFFSET_W-1:0] offset_of(input logic [ADDR_W-1:0] addr);
        return OFFSET_W'(addr);
    endfunction

endpackage

// File: rtl/cache_refill_ctrl.sv
// Line-refill engine: fetches a missing line one word at a time, streams each
// word into the data array and writes the tag only once the line is complete.
module cache_refill_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                miss_valid,
    output logic                                miss_ready,
    input  logic [ADDR_W-1:0]                   miss_addr,
    output logic                                mem_req_valid,
    input  logic                                mem_req_ready,
    output logic [ADDR_W-1:0]                   mem_req_addr,
    input  logic                                mem_rsp_valid,
    input  logic [DATA_W-1:0]                   mem_rsp_data,
    output logic                                fill_we,
    output logic [INDEX_W-1:0]                  fill_index,
    output logic [OFFSET_W-1:0]                 fill_offset,
    output logic [DATA_W-1:0]                   fill_data,
    output logic                                fill_tag_we,
    output logic [ADDR_W-INDEX_W-OFFSET_W-1:0]  fill_tag,
    output logic                                busy
);
    import cache_pkg::*;

    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    refill_state_t        state;
    logic [ADDR_W-1:0]    base;
    logic [OFFSET_W-1:0]  cnt;
    logic [OFFSET_W-1:0]  cnt_next;

    assign cnt_next = cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            base          <= '0;
            cnt           <= '0;
            miss_ready    <= 1'b1;
            busy          <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            fill_we       <= 1'b0;
            fill_index    <= '0;
            fill_offset   <= '0;
            fill_data     <= '0;
            fill_tag_we   <= 1'b0;
            fill_tag      <= '0;
        end else begin
            // NOTE: fill strobes and their payload default low every cycle, so each
            // write is a single-cycle pulse and the payload reads 0 when idle.
            fill_we     <= 1'b0;
            fill_index  <= '0;
            fill_offset <= '0;
            fill_data   <= '0;
            fill_tag_we <= 1'b0;
            fill_tag    <= '0;

            case (state)
                IDLE: begin
                    if (miss_valid) begin
                        base          <= miss_addr & LINE_MASK;
                        cnt           <= '0;
                        miss_ready    <= 1'b0;
                        busy          <= 1'b1;
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= miss_addr & LINE_MASK;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        mem_req_addr  <= '0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        fill_we     <= 1'b1;
                        fill_data   <= mem_rsp_data;
                        fill_offset <= cnt;
                        fill_index  <= index_of(base);
                        if (&cnt) begin
                            fill_tag_we <= 1'b1;
                            fill_tag    <= tag_of(base);
                            state       <= DONE;
                        end else begin
                            cnt           <= cnt_next;
                            mem_req_valid <= 1'b1;
                            // base offset bits are zero, so OR is a carry-free concatenation
                            mem_req_addr  <= base | ADDR_W'(cnt_next);
                            state         <= REQ;
                        end
                    end
                end
                DONE: begin
                    busy       <= 1'b0;
                    miss_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: a behavioural memory answers requests,
// expectations are queued when a miss is accepted and popped as the DUT fills.
module tb_cache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_valid;
    logic        miss_ready;
    logic [31:0] miss_addr;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        fill_we;
    logic [7:0]  fill_index;
    logic [3:0]  fill_offset;
    logic [31:0] fill_data;
    logic        fill_tag_we;
    logic [19:0] fill_tag;
    logic        busy;

    cache_refill_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .miss_valid    (miss_valid),
        .miss_ready    (miss_ready),
        .miss_addr     (miss_addr),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .fill_we       (fill_we),
        .fill_index    (fill_index),
        .fill_offset   (fill_offset),
        .fill_data     (fill_data),
        .fill_tag_we   (fill_tag_we),
        .fill_tag      (fill_tag),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  off;
        logic [31:0] data;
        logic [7:0]  idx;
    } fill_exp_t;

    typedef struct {
        logic [19:0] tag;
        logic [7:0]  idx;
    } tag_exp_t;

    logic [31:0] req_q[$];
    fill_exp_t   fill_q[$];
    tag_exp_t    tag_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Scenario knobs written by the stimulus process, read by the monitor.
    int stall_word   = -1;
    int stall_cycles = 0;
    int delay_word   = -1;
    int delay_cycles = 0;
    int exp_lat      = 33;
    bit spur_idle    = 1'b0;
    bit spur_req     = 1'b0;
    bit b2b          = 1'b0;
    bit mid_reset    = 1'b0;
    bit end_req      = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor, scoreboard and memory model share one negedge process.
    initial begin : monitor
        int          accept_edge;
        int          word_idx;
        int          stall_left;
        int          rsp_timer;
        int          tags_seen;
        int          b2b_tags;
        int          prev_tag_cyc;
        bit          tag_last;
        bit          in_refill;
        logic [31:0] base;
        logic [31:0] rsp_addr;
        fill_exp_t   fe;
        tag_exp_t    te;

        accept_edge = 0; word_idx = 0; stall_left = 0; rsp_timer = -1;
        tags_seen = 0; b2b_tags = 0; prev_tag_cyc = 0;
        tag_last = 1'b0; in_refill = 1'b0; base = '0; rsp_addr = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;

        forever begin
            @(negedge clk);
            if (end_req) begin
                check("queues_drained", req_q.size() + fill_q.size() + tag_q.size(), 0);
                check("tag_count", tags_seen, 7);
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end

            if (!rst_n) begin
                check("rst_miss_ready", miss_ready, 1);
                check("rst_busy", busy, 0);
                check("rst_req", {mem_req_valid, mem_req_addr}, 0);
                check("rst_fill", {fill_we, fill_tag_we, fill_data, fill_index, fill_offset, fill_tag}, 0);
                if (mid_reset) check("rst_words_left", fill_q.size(), 8);
                req_q.delete();
                fill_q.delete();
                tag_q.delete();
                rsp_timer = -1;
                tag_last = 1'b0;
                in_refill = 1'b0;
                mem_req_ready = 1'b0;
                mem_rsp_valid = 1'b0;
                mem_rsp_data = '0;
                continue;
            end

            if (tag_last) begin
                in_refill = 1'b0;
                tag_last = 1'b0;
            end
            check("busy", busy, in_refill);
            check("miss_ready", miss_ready, !in_refill);

            if (fill_we) begin
                if (fill_q.size() == 0) begin
                    check("fill_extra", fill_q.size(), 1);
                end else begin
                    fe = fill_q.pop_front();
                    check("fill_offset", fill_offset, fe.off);
                    check("fill_data", fill_data, fe.data);
                    check("fill_index", fill_index, fe.idx);
                end
            end else begin
                check("fill_idle", {fill_data, fill_index, fill_offset}, 0);
            end

            if (fill_tag_we) begin
                if (tag_q.size() == 0) begin
                    check("tag_extra", tag_q.size(), 1);
                end else begin
                    te = tag_q.pop_front();
                    check("tag_value", fill_tag, te.tag);
                    check("tag_index", fill_index, te.idx);
                    check("tag_with_last_fill", {fill_we, fill_offset}, {1'b1, 4'hF});
                    check("refill_latency", cyc - accept_edge + 1, exp_lat);
                end
                if (b2b) begin
                    b2b_tags++;
                    if (b2b_tags == 2) check("b2b_tag_gap", cyc - prev_tag_cyc, 34);
                end
                prev_tag_cyc = cyc;
                tags_seen++;
                tag_last = 1'b1;
            end else begin
                check("tag_idle", fill_tag, 0);
            end

            if (miss_valid && miss_ready) begin
                if (b2b && b2b_tags == 1) check("b2b_accept_edge", cyc + 1 - prev_tag_cyc, 2);
                accept_edge = cyc + 1;
                word_idx = 0;
                stall_left = stall_cycles;
                in_refill = 1'b1;
                base = miss_addr & 32'hFFFF_FFF0;
                for (int i = 0; i < 16; i++) begin
                    req_q.push_back(base + i);
                    fe.off = 4'(i);
                    fe.data = base + i;
                    fe.idx = base[11:4];
                    fill_q.push_back(fe);
                end
                te.tag = base[31:12];
                te.idx = base[11:4];
                tag_q.push_back(te);
            end

            mem_rsp_valid = 1'b0;
            mem_rsp_data = '0;
            mem_req_ready = 1'b0;
            if (rsp_timer == 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data = rsp_addr;
                rsp_timer = -1;
            end else if (rsp_timer > 0) begin
                rsp_timer--;
            end else if (spur_idle && !in_refill) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data = 32'h0BAD_0BAD;
            end

            if (mem_req_valid) begin
                if (req_q.size() == 0) begin
                    check("req_extra", req_q.size(), 1);
                end else begin
                    check("req_addr", mem_req_addr, req_q[0]);
                    if (word_idx == stall_word && stall_left > 0) begin
                        stall_left--;
                        if (spur_req) begin
                            mem_rsp_valid = 1'b1;
                            mem_rsp_data = 32'hDEAD_BEEF;
                        end
                    end else begin
                        mem_req_ready = 1'b1;
                        rsp_addr = req_q.pop_front();
                        rsp_timer = (word_idx == delay_word) ? delay_cycles : 0;
                        word_idx++;
                    end
                end
            end
        end
    end

    task automatic run_miss(input logic [31:0] addr, input int settle);
        @(posedge clk); #1;
        miss_valid = 1'b1;
        miss_addr = addr;
        @(posedge clk); #1;
        miss_valid = 1'b0;
        repeat (settle) @(posedge clk);
    endtask

    initial begin : stimulus
        rst_n = 1'b0;
        miss_valid = 1'b0;
        miss_addr = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // zero-latency memory
        exp_lat = 33;
        run_miss(32'h0000_1234, 45);

        // request stall on word 5, late response on word 9
        stall_word = 5; stall_cycles = 3;
        delay_word = 9; delay_cycles = 4;
        exp_lat = 40;
        run_miss(32'h0000_1234, 55);
        stall_word = -1; stall_cycles = 0;
        delay_word = -1; delay_cycles = 0;

        // top of the address space, no wrap
        exp_lat = 33;
        run_miss(32'hFFFF_FFF7, 45);

        // spurious responses in IDLE and stalled REQ, miss pulsed while busy
        spur_idle = 1'b1; spur_req = 1'b1;
        stall_word = 3; stall_cycles = 2;
        exp_lat = 35;
        repeat (3) @(posedge clk);
        @(posedge clk); #1;
        miss_valid = 1'b1;
        miss_addr = 32'h0000_2468;
        @(posedge clk); #1;
        miss_valid = 1'b0;
        repeat (10) @(posedge clk); #1;
        miss_valid = 1'b1;
        miss_addr = 32'hABCD_0000;
        repeat (3) @(posedge clk); #1;
        miss_valid = 1'b0;
        repeat (35) @(posedge clk); #1;
        spur_idle = 1'b0; spur_req = 1'b0;
        stall_word = -1; stall_cycles = 0;

        // reset after the 8th word, then a clean refill
        mid_reset = 1'b1;
        @(posedge clk); #1;
        miss_valid = 1'b1;
        miss_addr = 32'h0000_5678;
        @(posedge clk); #1;
        miss_valid = 1'b0;
        repeat (17) @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        mid_reset = 1'b0;
        repeat (3) @(posedge clk);
        exp_lat = 33;
        run_miss(32'h0000_9ABC, 45);

        // back-to-back misses with miss_valid held high
        b2b = 1'b1;
        @(posedge clk); #1;
        miss_valid = 1'b1;
        miss_addr = 32'h0000_4440;
        @(posedge clk); #1;
        miss_addr = 32'h0007_7770;
        repeat (34) @(posedge clk); #1;
        miss_valid = 1'b0;
        repeat (45) @(posedge clk);

        end_req = 1'b1;
    end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Line-refill engine that sits directly downstream of the direct-mapped cache (256 lines × 16 words, 20/8/4-bit tag/index/offset split). On a miss it accepts the faulting word address and fetches the 16-word block from main memory over a valid/ready request channel. It streams each returned word into the cache data array, then writes the tag once the whole line is present. All addresses are word addresses.

## Interface
- ADDR_W, 32, word-address width
- DATA_W, 32, word width
- INDEX_W, 8, cache index width
- OFFSET_W, 4, word-in-line width (line = 2**OFFSET_W words)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- miss_valid  in  1  cache requests a refill
- miss_ready  out  1  engine idle and able to accept a request
- miss_addr  in  ADDR_W  faulting word address
- mem_req_valid  out  1  read request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  word address being read
- mem_rsp_valid  in  1  read data returned (always accepted)
- mem_rsp_data  in  DATA_W  read data
- fill_we  out  1  write one word into the cache data array
- fill_index  out  INDEX_W  line being filled
- fill_offset  out  OFFSET_W  word within line
- fill_data  out  DATA_W  word to write
- fill_tag_we  out  1  write the tag for fill_index
- fill_tag  out  ADDR_W-INDEX_W-OFFSET_W  tag to write
- busy  out  1  refill in progress (state ≠ IDLE)

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: miss_ready=1. On miss_valid, latch base = {miss_addr[31:4], 4'b0}, index, and tag. Clear cnt (4-bit). Go to REQ.
- REQ: mem_req_valid=1, mem_req_addr={base[31:4], cnt}. Form the address by concatenation, not addition, so there is no carry. On mem_req_ready, go to WAIT. mem_req_addr stays stable while valid and not ready.
- WAIT: hold until mem_rsp_valid. Then register data, fill_offset=cnt, and fill_we for the next cycle. If cnt==15, go to DONE; else cnt+=1 and go to REQ.
- DONE: fill_tag_we=1 for one cycle with the latched tag and index. Go to IDLE.
- One outstanding memory read at a time. mem_rsp_valid outside WAIT is ignored.
- miss_valid is ignored while busy. The cache holds its request until miss_ready.
- The tag is written only after all 16 words, so a partially filled line never matches.
- Reset: state=IDLE, cnt=0. All outputs are 0 except miss_ready=1. Reset during a refill abandons it with no tag write; data words already written are left stale but tag-protected.

## Timing
- fill_we is a 1-cycle pulse, the cycle after the accepting mem_rsp_valid edge. fill_data, fill_offset, and fill_index are valid only while fill_we=1, and 0 otherwise.
- A response may arrive no earlier than the cycle after the request handshake. The minimum is 2 cycles per word.
- Best case, with the miss accepted at edge 0 and ready/response immediate: REQ edges 1,3,…,31; responses 2,4,…,32; fill_we cycles 3,5,…,33.
- In that best case, DONE is cycle 33. Both the last fill_we and fill_tag_we are asserted in cycle 33, so the cache must accept a simultaneous data and tag write. miss_ready returns in cycle 34.
- busy is high from the cycle after acceptance through DONE inclusive.
- Memory stalls (mem_req_ready low, late mem_rsp_valid) add cycles one-for-one with no loss of words.

## Structure
- Shared package cache_pkg holds:
  - TAG_W=20, INDEX_W=8, OFFSET_W=4, LINE_WORDS=16
  - the refill_state_t enum {IDLE, REQ, WAIT, DONE}
  - address-split helper functions (tag/index/offset)
- Single module. The counter and FSM are small enough that no sub-module is warranted.

## Test plan
- Miss at 0x0000_1234 with zero-latency memory returning data = address → requests 0x1230..0x123F in order; fill_we ×16 with offsets 0..15; fill_tag_we in cycle 33 with tag 0x00001 and index 0x23.
- Same miss, mem_req_ready low for 3 cycles on word 5 and rsp delayed 4 cycles on word 9 → addresses held stable; all 16 words correct; completion 7 cycles later than the zero-latency case.
- Miss at 0xFFFF_FFF7 → base 0xFFFF_FFF0, last request 0xFFFF_FFFF with no wrap; tag 0xFFFFF, index 0xFF.
- Spurious mem_rsp_valid in IDLE and REQ, plus miss_valid pulsed mid-refill → no fill_we, no second refill; miss_ready stays 0 until the cycle after DONE.
- rst_n asserted after the 8th word → all outputs 0 and miss_ready 1 immediately; no fill_tag_we; a new miss then completes normally.
- Back-to-back misses (miss_valid held high) → second refill accepted in the first IDLE cycle after DONE; the two fill_tag_we pulses are separated by ≥33 cycles.
